local_flit_injector: RTL and testbench
======================================

# local_flit_injector

Packetizer on the router LOCAL input port. It accepts a packet command (destination X/Y and payload length) and a stream of 32-bit payload words from the local tile. It emits a wormhole packet of head, body and tail flits on an `s_flit_req_t`/`s_flit_resp_t` pair wired directly to the router's local input module. The block owns flit framing, flow control and back-pressure toward the tile.

## Interface
Parameters:
- `ROUTER_X_ID`, default 0: X coordinate of the attached router.
- `ROUTER_Y_ID`, default 0: Y coordinate of the attached router.
- `DATA_FIFO_DEPTH`, default 4: payload skid FIFO depth. Power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `arst`  in  1  reset; synchronous, active-low.
- `cmd_valid_i`  in  1  packet command valid.
- `cmd_ready_o`  out  1  command accepted when both valid and ready are high.
- `cmd_x_dest_i`  in  `X_WIDTH`  destination X.
- `cmd_y_dest_i`  in  `Y_WIDTH`  destination Y.
- `cmd_len_i`  in  `PKT_LEN_WIDTH` (8)  payload words, 0–255.
- `data_valid_i`  in  1  payload word valid.
- `data_ready_o`  out  1  payload word accepted.
- `data_i`  in  `FLIT_DATA_WIDTH` (32)  payload word.
- `fout_req_o`  out  `s_flit_req_t`  flit request to router local input (`fvalid`, `flit`).
- `fout_resp_i`  in  `s_flit_resp_t`  `fready` from router.
- `busy_o`  out  1  packet in progress.
- `pkt_cnt_o`  out  32  packets fully sent (stats build only).
- `flit_cnt_o`  out  32  flits sent (stats build only).

## Operation
Flit = {type[1:0], payload[31:0]}. Types: `HEAD_FLIT`=2'b00, `BODY_FLIT`=2'b01, `TAIL_FLIT`=2'b10.

Head payload layout:
- `[31:31-X_WIDTH+1]` = x_dest.
- next `Y_WIDTH` bits = y_dest.
- `[7:0]` = len.
- remaining bits 0.

Framing:
- len=0: head only.
- len=1: head, tail.
- len=N: head, N-1 body, tail.

FSM:
- IDLE: `cmd_ready_o`=1. On command handshake, latch dest and len into `rem_q`, go to HEAD.
- HEAD: present head flit. On `fvalid&&fready`, go to IDLE if len=0, else PAYLOAD.
- PAYLOAD: pop the FIFO into the output register. Type is TAIL when `rem_q`==1, else BODY. `rem_q` decrements per transferred flit. After the tail transfers, go to IDLE.

Payload path:
- `data_ready_o` = FIFO not full, in any state.
- Words that arrive early (before their command) are buffered.
- Words beyond a packet's len are consumed by the next packet. The tile must keep word counts aligned with `cmd_len_i`.
- Destination equal to own ID is legal; the router ejects it locally.

## Timing
- Reset values: `cmd_ready_o`=0 during reset and 1 in the first cycle after; `data_ready_o`=0 during reset; `fout_req_o`='0; `busy_o`=0; counters 0; FIFO empty; FSM IDLE; `rem_q`=0.
- Output flit is registered. The head is valid the cycle after the command handshake.
- Once `fvalid`=1, flit contents and `fvalid` hold stable until `fready`=1. Never withdrawn.
- Throughput: 1 flit/cycle with `fready` held high and FIFO non-empty. No bubble between head and first body, or between tail and the next head. A new command is accepted in the cycle the tail transfers, giving the next head back-to-back.
- FIFO full: `data_ready_o`=0 in that cycle. A simultaneous pop and push when full is not accepted (ready is based on registered full).
- FIFO empty mid-packet: `fvalid` drops after the current flit transfers. `rem_q` is unchanged. Resumes the cycle after a word arrives.
- `busy_o`=1 from the cycle after cmd accept until the cycle after the last flit transfers.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is abandoned, so the router must be reset in the same cycle.

## Configuration
- `RAVENOC_INJ_STATS_EN` defined:
  - `flit_cnt_o` increments on every local `fvalid&&fready`.
  - `pkt_cnt_o` increments on every tail transfer and on every head transfer when len=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- `ravenoc_pkg` owns: flit type enum, `FLIT_DATA_WIDTH`, `PKT_LEN_WIDTH`, `X_WIDTH`/`Y_WIDTH`, head-field offsets, `s_flit_req_t`/`s_flit_resp_t`, and an `s_inj_state_t` enum (IDLE/HEAD/PAYLOAD).
- One sub-module, `inj_data_fifo`: synchronous FIFO, parameter DEPTH, full/empty flags, same synchronous active-low reset.

## Test plan
- Reset, then cmd (x=1, y=2, len=3), words A0..A2, `fready`=1 → head (type 00, x=1, y=2, len=3), body A0, body A1, tail A2 on 4 consecutive cycles; `busy_o` falls one cycle after the tail.
- len=0 cmd → exactly one head flit with len field 0; next cmd accepted the same cycle that head transfers.
- `fready`=0 for 5 cycles while the head is pending → head flit bit-identical throughout; transfers on the first cycle `fready`=1.
- Push 6 words with DEPTH=4 before any command → `data_ready_o`=0 after 4 words; cmd len=6 later → all 6 words emitted in order, tail = word 6.
- Reset asserted mid-body of a len=8 packet → next cycle `fout_req_o`='0, FIFO empty; new cmd after reset produces a clean head.
- Stats build, three packets of len 0, 1, 5 → `pkt_cnt_o`=3, `flit_cnt_o`=1+2+6=9; non-stats build → both 0.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Shared types and constants for the RaveNoC local flit injector:
// flit framing, head-field layout, request/response structs and injector FSM states.
package ravenoc_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int PKT_LEN_WIDTH   = 8;
    localparam int X_WIDTH         = 2;
    localparam int Y_WIDTH         = 2;

    localparam int HEAD_X_MSB   = FLIT_DATA_WIDTH - 1;
    localparam int HEAD_Y_MSB   = HEAD_X_MSB - X_WIDTH;
    localparam int HEAD_LEN_MSB = PKT_LEN_WIDTH - 1;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } flit_type_t;

    typedef struct packed {
        flit_type_t                 ftype;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } s_flit_t;

    typedef struct packed {
        logic    fvalid;
        s_flit_t flit;
    } s_flit_req_t;

    typedef struct packed {
        logic fready;
    } s_flit_resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEAD    = 2'b01,
        PAYLOAD = 2'b10
    } s_inj_state_t;

    // Head payload: x_dest at the top, y_dest right below, length in the low byte.
    function automatic logic [FLIT_DATA_WIDTH-1:0] build_head(
        input logic [X_WIDTH-1:0]       x,
        input logic [Y_WIDTH-1:0]       y,
        input logic [PKT_LEN_WIDTH-1:0] len
    );
        logic [FLIT_DATA_WIDTH-1:0] h;
        h = '0;
        h[HEAD_X_MSB -: X_WIDTH]         = x;
        h[HEAD_Y_MSB -: Y_WIDTH]         = y;
        h[HEAD_LEN_MSB -: PKT_LEN_WIDTH] = len;
        return h;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/inj_data_fifo.sv
// Payload skid FIFO for the local flit injector: power-of-two depth, registered pointers,
// full/empty derived from the pointers, synchronous active-low reset.
module inj_data_fifo
    import ravenoc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLIT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/local_flit_injector.sv
// Local-port packetizer: turns tile commands and payload words into head/body/tail flits.
// Defining RAVENOC_INJ_STATS_EN adds saturating packet and flit counters.
module local_flit_injector
    import ravenoc_pkg::*;
#(
    parameter int ROUTER_X_ID     = 0,
    parameter int ROUTER_Y_ID     = 0,
    parameter int DATA_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [X_WIDTH-1:0]         cmd_x_dest_i,
    input  logic [Y_WIDTH-1:0]         cmd_y_dest_i,
    input  logic [PKT_LEN_WIDTH-1:0]   cmd_len_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    input  logic [FLIT_DATA_WIDTH-1:0] data_i,
    output s_flit_req_t                fout_req_o,
    input  s_flit_resp_t               fout_resp_i,
    output logic                       busy_o,
    output logic [31:0]                pkt_cnt_o,
    output logic [31:0]                flit_cnt_o
);

    if ((DATA_FIFO_DEPTH < 2) || ((DATA_FIFO_DEPTH & (DATA_FIFO_DEPTH - 1)) != 0) ||
        (ROUTER_X_ID < 0) || (ROUTER_X_ID >= (1 << X_WIDTH)) ||
        (ROUTER_Y_ID < 0) || (ROUTER_Y_ID >= (1 << Y_WIDTH))) begin : g_param_check
        $error("local_flit_injector: illegal parameter set");
    end

    s_inj_state_t               state_q;
    s_flit_req_t                out_q;
    logic [PKT_LEN_WIDTH-1:0]   rem_q;
    logic                       run_q;
    logic                       busy_q;

    logic                       fready;
    logic                       out_free;
    logic                       pkt_end;
    logic                       cmd_fire;
    logic                       fifo_pop;
    logic                       fifo_push;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [FLIT_DATA_WIDTH-1:0] fifo_data;

    inj_data_fifo #(
        .DEPTH (DATA_FIFO_DEPTH),
        .WIDTH (FLIT_DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .push_i  (fifo_push),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // pkt_end marks the cycle the last flit leaves, so a new command can take its slot.
    always_comb begin
        fready   = fout_resp_i.fready;
        out_free = !out_q.fvalid || fready;
        pkt_end  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_end = 1'b0;
            end
            HEAD: begin
                if (fready) begin
                    if (rem_q == '0) begin
                        pkt_end = 1'b1;
                    end else begin
                        fifo_pop = !fifo_empty;
                    end
                end else begin
                    pkt_end = 1'b0;
                end
            end
            PAYLOAD: begin
                if (out_free) begin
                    if (rem_q == '0) begin
                        pkt_end = 1'b1;
                    end else begin
                        fifo_pop = !fifo_empty;
                    end
                end else begin
                    pkt_end = 1'b0;
                end
            end
            default: begin
                pkt_end = 1'b1;
            end
        endcase
        cmd_ready_o  = run_q && ((state_q == IDLE) || pkt_end);
        cmd_fire     = cmd_valid_i && cmd_ready_o;
        data_ready_o = run_q && !fifo_full;
        fifo_push    = data_valid_i && data_ready_o;
    end

    // Framing FSM with the registered output flit.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q <= IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (cmd_fire) begin
                out_q.fvalid     <= 1'b1;
                out_q.flit.ftype <= HEAD_FLIT;
                out_q.flit.data  <= build_head(cmd_x_dest_i, cmd_y_dest_i, cmd_len_i);
                rem_q            <= cmd_len_i;
                state_q          <= HEAD;
                busy_q           <= 1'b1;
            end else if (pkt_end) begin
                out_q.fvalid <= 1'b0;
                state_q      <= IDLE;
                busy_q       <= 1'b0;
            end else if (fifo_pop) begin
                out_q.fvalid     <= 1'b1;
                out_q.flit.ftype <= (rem_q == PKT_LEN_WIDTH'(1)) ? TAIL_FLIT : BODY_FLIT;
                out_q.flit.data  <= fifo_data;
                rem_q            <= rem_q - PKT_LEN_WIDTH'(1);
                state_q          <= PAYLOAD;
            end else if ((state_q == HEAD) && fready) begin
                // Head left but no payload buffered yet: bubble until a word arrives.
                out_q.fvalid <= 1'b0;
                state_q      <= PAYLOAD;
            end else if ((state_q == PAYLOAD) && out_free) begin
                out_q.fvalid <= 1'b0;
            end
        end
    end

    assign fout_req_o = out_q;
    assign busy_o     = busy_q;

`ifdef RAVENOC_INJ_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] flit_cnt_q;
    logic        flit_fire;
    logic        pkt_fire;

    // A packet completes on its tail, or on its head when it carries no payload.
    always_comb begin
        flit_fire = out_q.fvalid && fready;
        pkt_fire  = flit_fire &&
                    ((out_q.flit.ftype == TAIL_FLIT) ||
                     ((out_q.flit.ftype == HEAD_FLIT) &&
                      (out_q.flit.data[HEAD_LEN_MSB -: PKT_LEN_WIDTH] == '0)));
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!arst) begin
            pkt_cnt_q  <= 32'd0;
            flit_cnt_q <= 32'd0;
        end else begin
            if (flit_fire) begin
                flit_cnt_q <= sat_inc(flit_cnt_q);
            end
            if (pkt_fire) begin
                pkt_cnt_q <= sat_inc(pkt_cnt_q);
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign flit_cnt_o = flit_cnt_q;
`else
    assign pkt_cnt_o  = 32'd0;
    assign flit_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_local_flit_injector.sv
// Directed plus randomized bench for local_flit_injector against a packet-level reference model.
module tb_local_flit_injector;
    import ravenoc_pkg::*;

    logic                       clk = 1'b0;
    logic                       arst = 1'b0;
    logic                       cmd_valid = 1'b0;
    logic                       cmd_ready;
    logic [X_WIDTH-1:0]         cmd_x = '0;
    logic [Y_WIDTH-1:0]         cmd_y = '0;
    logic [PKT_LEN_WIDTH-1:0]   cmd_len = '0;
    logic                       data_valid = 1'b0;
    logic                       data_ready;
    logic [FLIT_DATA_WIDTH-1:0] data = '0;
    s_flit_req_t                req;
    s_flit_resp_t               resp;
    logic                       busy;
    logic [31:0]                pkt_cnt;
    logic [31:0]                flit_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [33:0] got_q[$];
    int          got_cyc[$];
    logic [33:0] exp_q[$];
    logic [31:0] word_q[$];
    logic        busy_log[int];
    int          exp_pkts = 0;
    int          exp_flits = 0;
    logic        prev_pending = 1'b0;
    logic [33:0] prev_flit = '0;

    local_flit_injector #(
        .ROUTER_X_ID     (0),
        .ROUTER_Y_ID     (0),
        .DATA_FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_x_dest_i (cmd_x),
        .cmd_y_dest_i (cmd_y),
        .cmd_len_i    (cmd_len),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .data_i       (data),
        .fout_req_o   (req),
        .fout_resp_i  (resp),
        .busy_o       (busy),
        .pkt_cnt_o    (pkt_cnt),
        .flit_cnt_o   (flit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: log transferred flits and check a pending flit never changes.
    always @(negedge clk) begin
        busy_log[cyc] = busy;
        if (arst && prev_pending) begin
            chk("hold_valid", 64'(req.fvalid), 64'd1);
            chk("hold_flit", 64'(req.flit), 64'(prev_flit));
        end
        if (arst && req.fvalid && resp.fready) begin
            got_q.push_back(req.flit);
            got_cyc.push_back(cyc);
        end
        prev_pending = arst && req.fvalid && !resp.fready;
        prev_flit    = req.flit;
    end

    function automatic logic [33:0] head_of(input int x, input int y, input int len);
        int unsigned v;
        v = (x << (32 - X_WIDTH)) | (y << (32 - X_WIDTH - Y_WIDTH)) | len;
        return {2'b00, v};
    endfunction

    // Reference model: a command consumes the next len words from the tile stream.
    task automatic model_cmd(input int x, input int y, input int len);
        exp_q.push_back(head_of(x, y, len));
        for (int i = 1; i <= len; i++) begin
            exp_q.push_back({(i == len) ? 2'b10 : 2'b01, word_q.pop_front()});
        end
        exp_pkts++;
        exp_flits += len + 1;
    endtask

    task automatic send_cmd(input int x, input int y, input int len, input bit keep,
                            output int acc);
        cmd_x = X_WIDTH'(x);
        cmd_y = Y_WIDTH'(y);
        cmd_len = PKT_LEN_WIDTH'(len);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300 && acc < 0; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = cyc;
            @(posedge clk);
            #1;
        end
        chk("cmd_accept", 64'(acc >= 0), 64'd1);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            bit ok;
            w = $urandom;
            data = w;
            data_valid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 300 && !ok; i++) begin
                @(negedge clk);
                if (data_ready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            chk("word_accept", 64'(ok), 64'd1);
            word_q.push_back(w);
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input bit rnd);
        for (int i = 0; i < 2000 && got_q.size() < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd) resp.fready = 1'($urandom_range(0, 1));
        end
        resp.fready = 1'b1;
        chk("flits_seen", 64'(got_q.size() >= n), 64'd1);
    endtask

    task automatic check_flits(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int a1, a2, rel, tail_c;
        logic [33:0] h;
        resp.fready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_fout", 64'(req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
        @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_data_ready", 64'(data_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic len=3 packet, words buffered ahead of the command
        push_words(3);
        send_cmd(1, 2, 3, 1'b0, a1);
        model_cmd(1, 2, 3);
        wait_flits(4, 1'b0);
        repeat (2) @(negedge clk);
        chk("head_latency", 64'(got_cyc[0]), 64'(a1 + 1));
        for (int i = 1; i < 4; i++) chk("back_to_back", 64'(got_cyc[i]), 64'(got_cyc[0] + i));
        tail_c = got_cyc[3];
        chk("busy_at_tail", 64'(busy_log[tail_c]), 64'd1);
        chk("busy_after_tail", 64'(busy_log[tail_c + 1]), 64'd0);
        check_flits("pkt_len3");
        @(posedge clk);
        #1;

        // len=0 head then an immediate second command
        push_words(1);
        send_cmd(2, 1, 0, 1'b1, a1);
        send_cmd(3, 0, 1, 1'b0, a2);
        model_cmd(2, 1, 0);
        model_cmd(3, 0, 1);
        wait_flits(3, 1'b0);
        chk("len0_field", 64'(got_q[0][7:0]), 64'd0);
        chk("next_cmd_same_cycle", 64'(a2), 64'(got_cyc[0]));
        chk("next_head_adjacent", 64'(got_cyc[1]), 64'(got_cyc[0] + 1));
        check_flits("pkt_len0");

        // Head held under back-pressure
        resp.fready = 1'b0;
        send_cmd(3, 3, 0, 1'b0, a1);
        model_cmd(3, 3, 0);
        h = head_of(3, 3, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(req.fvalid), 64'd1);
            chk("stall_flit", 64'(req.flit), 64'(h));
            @(posedge clk);
            #1;
        end
        resp.fready = 1'b1;
        rel = cyc;
        wait_flits(1, 1'b0);
        chk("stall_release_cycle", 64'(got_cyc[0]), 64'(rel));
        check_flits("pkt_stall");

        // Early words fill the FIFO, then a len=6 command drains them
        push_words(4);
        @(negedge clk);
        chk("fifo_full_ready", 64'(data_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            send_cmd(0, 3, 6, 1'b0, a1);
            push_words(2);
        join
        model_cmd(0, 3, 6);
        wait_flits(7, 1'b0);
        check_flits("pkt_len6");

        // Randomized packets with random back-pressure
        for (int p = 0; p < 10; p++) begin
            int x, y, len;
            x = $urandom_range(0, 3);
            y = $urandom_range(0, 3);
            len = $urandom_range(0, 9);
            fork
                send_cmd(x, y, len, 1'b0, a1);
                push_words(len);
            join
            model_cmd(x, y, len);
            wait_flits(len + 1, 1'b1);
            check_flits("rand_pkt");
        end

        // Reset in the middle of a len=8 body
        push_words(4);
        fork
            send_cmd(1, 1, 8, 1'b0, a1);
            push_words(4);
        join
        wait_flits(3, 1'b0);
        arst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_fout", 64'(req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 arst = 1'b1;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        word_q.delete();
        exp_pkts = 0;
        exp_flits = 0;
        @(posedge clk);
        #1;

        // Clean packets after reset: len 0, 1, 5
        send_cmd(2, 2, 0, 1'b0, a1);
        model_cmd(2, 2, 0);
        fork
            send_cmd(1, 0, 1, 1'b0, a1);
            push_words(1);
        join
        model_cmd(1, 0, 1);
        fork
            send_cmd(0, 1, 5, 1'b0, a1);
            push_words(5);
        join
        model_cmd(0, 1, 5);
        wait_flits(9, 1'b0);
        check_flits("post_rst");
        repeat (2) @(negedge clk);
`ifdef RAVENOC_INJ_STATS_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
        chk("flit_cnt", 64'(flit_cnt), 64'(exp_flits));
`else
        chk("pkt_cnt_off", 64'(pkt_cnt), 64'd0);
        chk("flit_cnt_off", 64'(flit_cnt), 64'd0);
`endif
        chk("idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
